// File: rtl/adc_trig_pkg.sv
// Shared types and constants for the ADC capture trigger sequencer.
package adc_trig_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TRIG_RISE = 2'b00,
        TRIG_FALL = 2'b01,
        TRIG_HIGH = 2'b10,
        TRIG_LOW  = 2'b11
    } trig_mode_e;

    // Capture cycles during which capture_stop_i is disregarded.
    localparam int unsigned STOP_GUARD = 2;

endpackage

// File: rtl/trig_sync_edge.sv
// Multi-stage synchroniser for an asynchronous level plus a history flop
// providing rise/fall detection on the synchronised value.
module trig_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_trigger_ctrl.sv
// Capture sequencer in the ADC sample-clock domain: arms, detects the trigger
// (or times out), applies the post-trigger offset and drives capture-go.
module adc_trigger_ctrl
    import adc_trig_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             adc_sampleclk,
    input  logic             ddr_usrreset,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_in,
    input  logic [1:0]       trig_mode_i,
    input  logic [CNT_W-1:0] offset_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             capture_stop_i,
    output logic             capture_go_o,
    output logic             trig_status_o,
    output logic             armed_o,
    output logic             triggered_o,
    output logic             timed_out_o,
    output logic             done_o
);

    localparam logic [1:0] GUARD_LAST = 2'(STOP_GUARD);

    logic trig_lvl, trig_rise, trig_fall;
    logic arm_rise, arm_lvl_unused, arm_fall_unused;

    trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk_i   (adc_sampleclk),
        .rst_i   (ddr_usrreset),
        .async_i (trig_in),
        .level_o (trig_lvl),
        .rise_o  (trig_rise),
        .fall_o  (trig_fall)
    );

    trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
        .clk_i   (adc_sampleclk),
        .rst_i   (ddr_usrreset),
        .async_i (arm_i),
        .level_o (arm_lvl_unused),
        .rise_o  (arm_rise),
        .fall_o  (arm_fall_unused)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       guard_q, guard_d;
    logic             timed_out_q, timed_out_d;
    logic             triggered_q, triggered_d;
    logic             trig_status_q;
    logic             trig_evt, tmo_hit;

    always_comb begin
        case (trig_mode_e'(trig_mode_i))
            TRIG_RISE: trig_evt = trig_rise;
            TRIG_FALL: trig_evt = trig_fall;
            TRIG_HIGH: trig_evt = trig_lvl;
            TRIG_LOW:  trig_evt = ~trig_lvl;
            default:   trig_evt = 1'b0;
        endcase
    end

    assign tmo_hit = (tmo_q != '0) && (timer_q == tmo_q - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        tmo_d       = tmo_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        guard_d     = guard_q;
        timed_out_d = timed_out_q;
        triggered_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm_rise) begin
                    state_d     = ARMED;
                    off_d       = offset_i;
                    tmo_d       = timeout_i;
                    timed_out_d = 1'b0;
                    timer_d     = '0;
                end
            end
            ARMED: begin
                timer_d = timer_q + CNT_W'(1);
                if (trig_evt || tmo_hit) begin
                    triggered_d = 1'b1;
                    timed_out_d = ~trig_evt;
                    guard_d     = '0;
                    if (off_q == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = off_q;
                    end
                end
            end
            DELAY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // The DDR stage's stop flag may still hold the previous run's value.
                if (guard_q < GUARD_LAST) begin
                    guard_d = guard_q + 2'd1;
                end else if (capture_stop_i) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d     = IDLE;
            timed_out_d = timed_out_q;
            triggered_d = 1'b0;
        end
    end

    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            state_q       <= IDLE;
            off_q         <= '0;
            tmo_q         <= '0;
            timer_q       <= '0;
            cnt_q         <= '0;
            guard_q       <= '0;
            timed_out_q   <= 1'b0;
            triggered_q   <= 1'b0;
            trig_status_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            tmo_q         <= tmo_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            guard_q       <= guard_d;
            timed_out_q   <= timed_out_d;
            triggered_q   <= triggered_d;
            trig_status_q <= trig_lvl;
        end
    end

    assign capture_go_o  = (state_q == CAPTURE);
    assign armed_o       = (state_q == ARMED);
    assign done_o        = (state_q == DONE);
    assign triggered_o   = triggered_q;
    assign timed_out_o   = timed_out_q;
    assign trig_status_o = trig_status_q;

endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// Directed and randomised runs of adc_trigger_ctrl against cycle counts
// derived from the sequencing rules (sync latency, timeout, offset, stop guard).
module tb_adc_trigger_ctrl;

    localparam int NEVER = 1000000;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trig, stop;
    logic [1:0]  mode;
    logic [31:0] off, tmo;
    logic        go, status, armed, trg, tout, done;

    int errors = 0;
    int checks = 0;
    bit exp_to = 1'b0;

    always #5 clk = ~clk;

    adc_trigger_ctrl #(.SYNC_STAGES(2), .CNT_W(32)) dut (
        .adc_sampleclk  (clk),
        .ddr_usrreset   (rst),
        .arm_i          (arm),
        .abort_i        (abort),
        .trig_in        (trig),
        .trig_mode_i    (mode),
        .offset_i       (off),
        .timeout_i      (tmo),
        .capture_stop_i (stop),
        .capture_go_o   (go),
        .trig_status_o  (status),
        .armed_o        (armed),
        .triggered_o    (trg),
        .timed_out_o    (tout),
        .done_o         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // c: ARMED cycle at which trig_in flips to its active level (-1: active
    // before arming, -2: never). t: timeout, o: offset, k: capture cycle at
    // which stop rises; stop_pre holds stop high from before the run.
    task automatic do_run(input logic [1:0] m, input int c, input int t,
                          input int o, input int k, input bit stop_pre);
        int je, jt, fire, n, ks, g;
        bit active, to_exp;
        active = (m == 2'b00) || (m == 2'b10);
        if (c == -1)     je = m[1] ? 0 : NEVER;
        else if (c < 0)  je = NEVER;
        else             je = c + 2;
        jt     = (t != 0) ? t - 1 : NEVER;
        fire   = (je < jt) ? je : jt;
        to_exp = (jt < je);

        arm = 0; abort = 0; stop = stop_pre; mode = m;
        off = o; tmo = t; trig = (c == -1) ? active : !active;
        ticks(3);
        chk("to_sticky", tout, exp_to);
        arm = 1;
        ticks(2);
        chk("arm_wait", armed, 0);
        tick();
        chk("arm_lat", armed, 1);
        chk("to_clr", tout, 0);
        exp_to = 0;

        for (int i = 0; i <= fire; i++) begin
            if (i == c) trig = active;
            if (i == fire) chk("pre_trig", trg, 0);
            tick();
        end
        chk("trig_pulse", trg, 1);
        chk("armed_off", armed, 0);
        chk("timed_out", tout, to_exp);
        exp_to = to_exp;

        n = 0;
        while (go !== 1'b1 && n <= o + 4) begin
            tick();
            n++;
        end
        chk("go_latency", n, o);

        ks = stop_pre ? 0 : k;
        g  = (ks > 2) ? ks : 2;
        for (int i = 0; i <= g; i++) begin
            if (i == ks) stop = 1;
            if (i == 1) chk("pulse_once", trg, 0);
            if (i == g) chk("go_guard", go, 1);
            tick();
        end
        chk("go_fall", go, 0);
        chk("done", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; arm = 0; abort = 0; trig = 0; stop = 0;
        mode = 2'b00; off = '0; tmo = '0;
        ticks(2);
        chk("rst_go", go, 0);
        chk("rst_armed", armed, 0);
        chk("rst_trg", trg, 0);
        chk("rst_to", tout, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        rst = 0;
        tick();

        trig = 1;
        ticks(2);
        chk("status_lat0", status, 0);
        tick();
        chk("status_hi", status, 1);
        trig = 0;
        ticks(3);
        chk("status_lo", status, 0);
        chk("idle_no_trg", trg, 0);

        do_run(2'b00, 3, 0, 0, 4, 0);
        do_run(2'b10, -1, 0, 100, 0, 1);
        do_run(2'b00, -2, 50, 7, 3, 0);
        do_run(2'b10, -1, 1, 3, 2, 0);
        do_run(2'b00, 8, 11, 0, 0, 0);
        do_run(2'b01, 5, 0, 1, 1, 0);
        do_run(2'b11, -2, 9, 2, 5, 0);

        for (int r = 0; r < 8; r++) begin
            logic [1:0] rm;
            int rc, rt, ro, rk;
            rm = 2'($urandom_range(3, 0));
            rc = $urandom_range(30, 0);
            rt = ($urandom_range(1, 0) == 1) ? $urandom_range(40, 1) : 0;
            ro = $urandom_range(20, 0);
            rk = $urandom_range(6, 0);
            do_run(rm, rc, rt, ro, rk, 0);
        end

        // abort during DELAY after a timeout-caused trigger
        arm = 0; stop = 0; mode = 2'b00; trig = 0; off = 1000; tmo = 5;
        ticks(3);
        arm = 1;
        ticks(3);
        chk("ab_armed", armed, 1);
        ticks(5);
        chk("ab_trg", trg, 1);
        chk("ab_to", tout, 1);
        chk("ab_delay_go", go, 0);
        ticks(3);
        arm = 0;
        ticks(3);
        arm = 1;
        ticks(2);
        abort = 1;
        tick();
        chk("ab_dly_go", go, 0);
        chk("ab_dly_armed", armed, 0);
        chk("ab_dly_done", done, 0);
        chk("ab_to_keep", tout, 1);
        abort = 0;
        ticks(4);
        chk("ab_arm_ign", armed, 0);
        chk("ab_idle_go", go, 0);

        // abort in IDLE coinciding with an arm edge
        arm = 0;
        ticks(3);
        arm = 1;
        ticks(2);
        abort = 1;
        tick();
        chk("ab_idle_armed", armed, 0);
        chk("ab_idle_to", tout, 1);
        abort = 0;
        ticks(3);
        chk("ab_idle_stay", armed, 0);

        // abort during CAPTURE, together with stop
        arm = 0; off = 0; tmo = 0; mode = 2'b10; trig = 0;
        ticks(3);
        arm = 1; trig = 1;
        ticks(3);
        chk("abc_armed", armed, 1);
        tick();
        chk("abc_go", go, 1);
        chk("abc_to", tout, 0);
        ticks(3);
        abort = 1; stop = 1;
        tick();
        chk("abc_go_off", go, 0);
        chk("abc_done", done, 0);
        chk("abc_armed_off", armed, 0);
        abort = 0; stop = 0;

        // reset in the middle of CAPTURE
        arm = 0; trig = 0;
        ticks(3);
        arm = 1; trig = 1;
        ticks(3);
        chk("rc_armed", armed, 1);
        tick();
        chk("rc_go", go, 1);
        tick();
        #2 rst = 1;
        #1;
        chk("rc_go_async", go, 0);
        chk("rc_armed0", armed, 0);
        chk("rc_done0", done, 0);
        chk("rc_trg0", trg, 0);
        chk("rc_to0", tout, 0);
        chk("rc_status0", status, 0);
        arm = 0; trig = 0;
        #2 rst = 0;
        tick();
        arm = 1;
        ticks(2);
        chk("rc_arm_wait", armed, 0);
        tick();
        chk("rc_rearm", armed, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
